// File: rtl/stage_decode_pkg.sv
// Shared decode definitions: opcode encoding, instruction field positions and
// PC width. Reused by the execute stage.
package stage_decode_pkg;

    localparam int A_BITS = 8;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 11;
    localparam int DST_MSB  = 10;
    localparam int DST_LSB  = 8;
    localparam int SRC0_MSB = 5;
    localparam int SRC0_LSB = 3;
    localparam int SRC1_MSB = 2;
    localparam int SRC1_LSB = 0;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    typedef enum logic [4:0] {
        OP_NOP   = 5'd0,
        OP_ADD   = 5'd1,
        OP_SUB   = 5'd2,
        OP_AND   = 5'd3,
        OP_OR    = 5'd4,
        OP_XOR   = 5'd5,
        OP_LOAD  = 5'd6,
        OP_STORE = 5'd7,
        OP_LOADC = 5'd8,
        OP_JMP   = 5'd9,
        OP_JMPZ  = 5'd10,
        OP_HALT  = 5'd31
    } opcode_t;

endpackage

// File: rtl/decode_fields.sv
// Pure combinational field extraction and opcode classification for one
// 16-bit instruction word.
module decode_fields
    import stage_decode_pkg::*;
(
    input  logic [15:0] instr_i,
    output opcode_t     op_o,
    output logic [2:0]  dst_o,
    output logic [2:0]  src0_o,
    output logic [2:0]  src1_o,
    output logic [7:0]  imm_o,
    output logic        we_o,
    output logic        rd_src0_o,
    output logic        rd_src1_o,
    output logic        illegal_o
);

    logic [4:0] raw_op;

    assign raw_op = instr_i[OP_MSB:OP_LSB];
    assign dst_o  = instr_i[DST_MSB:DST_LSB];
    assign src0_o = instr_i[SRC0_MSB:SRC0_LSB];
    assign src1_o = instr_i[SRC1_MSB:SRC1_LSB];
    assign imm_o  = instr_i[IMM_MSB:IMM_LSB];

    // Unknown opcodes come out as NOP so nothing downstream sees a stray value.
    always_comb begin
        op_o      = OP_NOP;
        we_o      = 1'b0;
        rd_src0_o = 1'b0;
        rd_src1_o = 1'b0;
        illegal_o = 1'b0;
        case (raw_op)
            OP_NOP:   op_o = OP_NOP;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                op_o      = opcode_t'(raw_op);
                we_o      = 1'b1;
                rd_src0_o = 1'b1;
                rd_src1_o = 1'b1;
            end
            OP_LOAD: begin
                op_o      = OP_LOAD;
                we_o      = 1'b1;
                rd_src0_o = 1'b1;
            end
            OP_STORE, OP_JMPZ: begin
                op_o      = opcode_t'(raw_op);
                rd_src0_o = 1'b1;
                rd_src1_o = 1'b1;
            end
            OP_LOADC: begin
                op_o = OP_LOADC;
                we_o = 1'b1;
            end
            OP_JMP: begin
                op_o      = OP_JMP;
                rd_src0_o = 1'b1;
            end
            OP_HALT:  op_o = OP_HALT;
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/stage_decode.sv
// Decode stage: registers the decoded instruction, detects load-use hazards,
// latches HALT and pulses on illegal opcodes.
module stage_decode
    import stage_decode_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [15:0]       instruction_i,
    input  logic [A_BITS-1:0] pc_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              halt_o,
    output logic              illegal_o,
    output logic              dec_valid_o,
    output opcode_t           dec_op_o,
    output logic [2:0]        dec_dst_o,
    output logic [2:0]        dec_src0_o,
    output logic [2:0]        dec_src1_o,
    output logic [7:0]        dec_imm_o,
    output logic              dec_we_o,
    output logic [A_BITS-1:0] dec_pc_o
);

    opcode_t     f_op;
    logic [2:0]  f_dst, f_src0, f_src1;
    logic [7:0]  f_imm;
    logic        f_we, f_rd_src0, f_rd_src1, f_illegal;

    logic              valid_q, valid_d;
    opcode_t           op_q, op_d;
    logic [2:0]        dst_q, dst_d, src0_q, src0_d, src1_q, src1_d;
    logic [7:0]        imm_q, imm_d;
    logic              we_q, we_d;
    logic [A_BITS-1:0] pc_q, pc_d;
    logic              halt_q, halt_d;
    logic              illegal_q, illegal_d;
    logic              stall;
    logic              bubble;

    decode_fields u_fields (
        .instr_i   (instruction_i),
        .op_o      (f_op),
        .dst_o     (f_dst),
        .src0_o    (f_src0),
        .src1_o    (f_src1),
        .imm_o     (f_imm),
        .we_o      (f_we),
        .rd_src0_o (f_rd_src0),
        .rd_src1_o (f_rd_src1),
        .illegal_o (f_illegal)
    );

    // Only a valid LOAD sitting in the decode register can create a hazard.
    always_comb begin
        stall = valid_q && (op_q == OP_LOAD) && !flush_i && !halt_q &&
                ((f_rd_src0 && (f_src0 == dst_q)) ||
                 (f_rd_src1 && (f_src1 == dst_q)));
    end

    always_comb begin
        bubble    = flush_i || stall || halt_q || f_illegal || (f_op == OP_HALT);
        valid_d   = !bubble;
        op_d      = bubble ? OP_NOP : f_op;
        dst_d     = bubble ? 3'd0 : f_dst;
        src0_d    = bubble ? 3'd0 : f_src0;
        src1_d    = bubble ? 3'd0 : f_src1;
        imm_d     = bubble ? 8'd0 : f_imm;
        we_d      = bubble ? 1'b0 : f_we;
        pc_d      = bubble ? pc_q : pc_i;
        halt_d    = halt_q || (!flush_i && (f_op == OP_HALT));
        illegal_d = !flush_i && !halt_q && f_illegal;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q   <= 1'b0;
            op_q      <= OP_NOP;
            dst_q     <= 3'd0;
            src0_q    <= 3'd0;
            src1_q    <= 3'd0;
            imm_q     <= 8'd0;
            we_q      <= 1'b0;
            pc_q      <= '0;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            src0_q    <= src0_d;
            src1_q    <= src1_d;
            imm_q     <= imm_d;
            we_q      <= we_d;
            pc_q      <= pc_d;
            halt_q    <= halt_d;
            illegal_q <= illegal_d;
        end
    end

    assign stall_o     = stall;
    assign halt_o      = halt_q;
    assign illegal_o   = illegal_q;
    assign dec_valid_o = valid_q;
    assign dec_op_o    = op_q;
    assign dec_dst_o   = dst_q;
    assign dec_src0_o  = src0_q;
    assign dec_src1_o  = src1_q;
    assign dec_imm_o   = imm_q;
    assign dec_we_o    = we_q;
    assign dec_pc_o    = pc_q;

endmodule

// File: tb/tb_stage_decode.sv
// Directed, table-driven bench for stage_decode plus hand-written reset
// sequences around halt and stall.
module tb_stage_decode;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] instruction_i;
    logic [7:0]  pc_i;
    logic        flush_i;
    logic        stall_o, halt_o, illegal_o, dec_valid_o, dec_we_o;
    logic [4:0]  dec_op_o;
    logic [2:0]  dec_dst_o, dec_src0_o, dec_src1_o;
    logic [7:0]  dec_imm_o, dec_pc_o;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  pc;
        logic        flush;
        logic        exp_stall;
        logic        exp_valid;
        logic [4:0]  exp_op;
        logic [2:0]  exp_dst, exp_src0, exp_src1;
        logic [7:0]  exp_imm;
        logic        exp_we;
        logic [7:0]  exp_pc;
        logic        exp_illegal;
        logic        exp_halt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk_i = ~clk_i;

    stage_decode dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .instruction_i (instruction_i),
        .pc_i          (pc_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .halt_o        (halt_o),
        .illegal_o     (illegal_o),
        .dec_valid_o   (dec_valid_o),
        .dec_op_o      (dec_op_o),
        .dec_dst_o     (dec_dst_o),
        .dec_src0_o    (dec_src0_o),
        .dec_src1_o    (dec_src1_o),
        .dec_imm_o     (dec_imm_o),
        .dec_we_o      (dec_we_o),
        .dec_pc_o      (dec_pc_o)
    );

    function automatic vec_t mk(logic [15:0] instr, logic [7:0] pc, logic flush,
                                logic stall, logic valid, logic [4:0] op,
                                logic [2:0] dst, logic [2:0] s0, logic [2:0] s1,
                                logic [7:0] imm, logic we, logic [7:0] epc,
                                logic ill, logic halt);
        vec_t v;
        v.instr = instr;  v.pc = pc;  v.flush = flush;
        v.exp_stall = stall;  v.exp_valid = valid;  v.exp_op = op;
        v.exp_dst = dst;  v.exp_src0 = s0;  v.exp_src1 = s1;
        v.exp_imm = imm;  v.exp_we = we;  v.exp_pc = epc;
        v.exp_illegal = ill;  v.exp_halt = halt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " stall"},   stall_o,     0);
        checkOutput({tag, " halt"},    halt_o,      0);
        checkOutput({tag, " illegal"}, illegal_o,   0);
        checkOutput({tag, " valid"},   dec_valid_o, 0);
        checkOutput({tag, " op"},      dec_op_o,    0);
        checkOutput({tag, " dst"},     dec_dst_o,   0);
        checkOutput({tag, " src0"},    dec_src0_o,  0);
        checkOutput({tag, " src1"},    dec_src1_o,  0);
        checkOutput({tag, " imm"},     dec_imm_o,   0);
        checkOutput({tag, " we"},      dec_we_o,    0);
        checkOutput({tag, " pc"},      dec_pc_o,    0);
    endtask

    // Stall is checked combinationally before the edge, the rest after it.
    task automatic applyStimulus(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk_i);
        instruction_i = v.instr;
        pc_i          = v.pc;
        flush_i       = v.flush;
        #1;
        checkOutput({t, " stall"}, stall_o, v.exp_stall);
        @(posedge clk_i);
        #1;
        checkOutput({t, " valid"},   dec_valid_o, v.exp_valid);
        checkOutput({t, " op"},      dec_op_o,    v.exp_op);
        checkOutput({t, " we"},      dec_we_o,    v.exp_we);
        checkOutput({t, " pc"},      dec_pc_o,    v.exp_pc);
        checkOutput({t, " illegal"}, illegal_o,   v.exp_illegal);
        checkOutput({t, " halt"},    halt_o,      v.exp_halt);
        if (v.exp_valid) begin
            checkOutput({t, " dst"},  dec_dst_o,  v.exp_dst);
            checkOutput({t, " src0"}, dec_src0_o, v.exp_src0);
            checkOutput({t, " src1"}, dec_src1_o, v.exp_src1);
            checkOutput({t, " imm"},  dec_imm_o,  v.exp_imm);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //              instr    pc  fl st va op  dst s0 s1 imm  we epc il ha
        vecs.push_back(mk(16'h0B0A, 5,  0, 0, 1, 1,  3, 1, 2, 8'h0A, 1, 5,  0, 0));
        vecs.push_back(mk(16'h457F, 6,  0, 0, 1, 8,  5, 7, 7, 8'h7F, 1, 6,  0, 0));
        vecs.push_back(mk(16'h3208, 7,  0, 0, 1, 6,  2, 1, 0, 8'h08, 1, 7,  0, 0));
        vecs.push_back(mk(16'h0C10, 8,  0, 1, 0, 0,  0, 0, 0, 8'h00, 0, 7,  0, 0));
        vecs.push_back(mk(16'h0C10, 8,  0, 0, 1, 1,  4, 2, 0, 8'h10, 1, 8,  0, 0));
        vecs.push_back(mk(16'h3208, 9,  0, 0, 1, 6,  2, 1, 0, 8'h08, 1, 9,  0, 0));
        vecs.push_back(mk(16'h0C08, 10, 0, 0, 1, 1,  4, 1, 0, 8'h08, 1, 10, 0, 0));
        vecs.push_back(mk(16'h3208, 11, 0, 0, 1, 6,  2, 1, 0, 8'h08, 1, 11, 0, 0));
        vecs.push_back(mk(16'h0C10, 12, 1, 0, 0, 0,  0, 0, 0, 8'h00, 0, 11, 0, 0));
        vecs.push_back(mk(16'h0C10, 12, 0, 0, 1, 1,  4, 2, 0, 8'h10, 1, 12, 0, 0));
        vecs.push_back(mk(16'h0000, 13, 0, 0, 1, 0,  0, 0, 0, 8'h00, 0, 13, 0, 0));
        vecs.push_back(mk(16'h5800, 14, 0, 0, 0, 0,  0, 0, 0, 8'h00, 0, 13, 1, 0));
        vecs.push_back(mk(16'h5800, 15, 0, 0, 0, 0,  0, 0, 0, 8'h00, 0, 13, 1, 0));
        vecs.push_back(mk(16'h0B0A, 16, 0, 0, 1, 1,  3, 1, 2, 8'h0A, 1, 16, 0, 0));
        vecs.push_back(mk(16'h3208, 17, 0, 0, 1, 6,  2, 1, 0, 8'h08, 1, 17, 0, 0));
        vecs.push_back(mk(16'h3802, 18, 0, 1, 0, 0,  0, 0, 0, 8'h00, 0, 17, 0, 0));
        vecs.push_back(mk(16'h3802, 18, 0, 0, 1, 7,  0, 0, 2, 8'h02, 0, 18, 0, 0));
        vecs.push_back(mk(16'h3208, 19, 0, 0, 1, 6,  2, 1, 0, 8'h08, 1, 19, 0, 0));
        vecs.push_back(mk(16'h4212, 20, 0, 0, 1, 8,  2, 2, 2, 8'h12, 1, 20, 0, 0));
        vecs.push_back(mk(16'hF800, 21, 0, 0, 0, 0,  0, 0, 0, 8'h00, 0, 20, 0, 1));
        vecs.push_back(mk(16'h0B0A, 22, 0, 0, 0, 0,  0, 0, 0, 8'h00, 0, 20, 0, 1));
        vecs.push_back(mk(16'h5800, 23, 0, 0, 0, 0,  0, 0, 0, 8'h00, 0, 20, 0, 1));

        rst_i         = 1'b0;
        instruction_i = 16'h0B0A;
        pc_i          = 8'd3;
        flush_i       = 1'b0;
        #12;
        checkResetOutputs("por");
        @(negedge clk_i);
        rst_i = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Halt survives idle cycles, then reset clears it immediately.
        @(negedge clk_i);
        checkOutput("halt sticky", halt_o, 1);
        rst_i = 1'b0;
        #1;
        checkResetOutputs("halt rst");
        @(negedge clk_i);
        instruction_i = 16'h0B0A;
        pc_i          = 8'd5;
        rst_i         = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("post-halt valid", dec_valid_o, 1);
        checkOutput("post-halt op",    dec_op_o,    1);
        checkOutput("post-halt pc",    dec_pc_o,    5);
        checkOutput("post-halt halt",  halt_o,      0);

        // Reset in the middle of a stall leaves no pending hazard behind.
        @(negedge clk_i);
        instruction_i = 16'h3208;
        pc_i          = 8'd6;
        @(posedge clk_i);
        @(negedge clk_i);
        instruction_i = 16'h0C10;
        pc_i          = 8'd7;
        #1;
        checkOutput("pre-rst stall", stall_o, 1);
        #1;
        rst_i = 1'b0;
        #1;
        checkResetOutputs("stall rst");
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checkOutput("post-rst stall", stall_o, 0);
        @(posedge clk_i);
        #1;
        checkOutput("post-rst valid", dec_valid_o, 1);
        checkOutput("post-rst op",    dec_op_o,    1);
        checkOutput("post-rst dst",   dec_dst_o,   4);
        checkOutput("post-rst pc",    dec_pc_o,    7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/stage_decode.md
STAGE_DECODE -- requirements
Module: stage_decode

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning):
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- instruction_i  in  16  instruction word from the fetch instruction register
- pc_i  in  A_BITS  PC associated with instruction_i
- flush_i  in  1  kill in-flight decode, from execute on a taken jump
- stall_o  out  1  hold fetch PC and instruction register this cycle
- halt_o  out  1  sticky; HALT decoded
- illegal_o  out  1  one-cycle pulse; unknown opcode decoded
- dec_valid_o  out  1  decode register holds a real instruction
- dec_op_o  out  5  opcode (opcode_t)
- dec_dst_o, dec_src0_o, dec_src1_o  out  3 each  register indices
- dec_imm_o  out  8  immediate
- dec_we_o  out  1  instruction writes dst
- dec_pc_o  out  A_BITS  PC of decoded instruction

Function
REQ-002 Field layout SHALL be: opcode [15:11], dst [10:8], src0 [5:3], src1 [2:0], imm8 [7:0].
REQ-003 Opcodes SHALL be: NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, LOAD=6, STORE=7, LOADC=8, JMP=9, JMPZ=10, HALT=31; all other opcodes are illegal.
REQ-004 Register reads: ADD..XOR read src0 and src1; LOAD and JMP read src0; STORE and JMPZ read src0 and src1; all other opcodes read none.
REQ-005 dec_we_o SHALL be 1 for ADD..XOR, LOAD and LOADC, else 0.
REQ-006 All dec_* outputs SHALL be registered, with latency 1 clock from instruction_i to dec_*.
REQ-007 Load-use hazard: stall_o SHALL be combinational, 1 when dec_valid_o=1, dec_op_o=LOAD, and the incoming instruction reads a register equal to dec_dst_o.
REQ-008 While stall_o=1, the decode register SHALL load a bubble: dec_valid_o=0, op NOP, dec_we_o=0.
REQ-009 A stall SHALL last exactly one cycle; the held instruction decodes on the next edge.
REQ-010 flush_i=1 SHALL load a bubble on the next edge and force stall_o=0; flush SHALL win over stall, halt and illegal.
REQ-011 HALT SHALL set halt_o on the edge it is registered, emitted as a bubble.
REQ-012 While halt_o=1, every instruction SHALL decode as a bubble and stall_o SHALL be 0.
REQ-013 halt_o SHALL clear only on reset.
REQ-014 An illegal opcode SHALL register as a bubble and pulse illegal_o for exactly one cycle, aligned with the bubble.
REQ-015 The opcode value 0 SHALL decode as a valid NOP (dec_valid_o=1, dec_we_o=0).
REQ-016 A non-bubble SHALL pass dec_pc_o = pc_i.
REQ-017 A bubble SHALL hold dec_pc_o unchanged.

Reset
REQ-018 While rst_i=0, all outputs SHALL be 0, including halt_o and dec_pc_o, and stall_o SHALL be 0.
REQ-019 Reset asserted mid-stall or mid-halt SHALL take effect immediately, with no state retained.
REQ-020 After release, the first rising edge SHALL decode instruction_i normally.

Structure
REQ-021 A shared package SHALL hold opcode_t (5-bit enum), the field-position constants and A_BITS.
REQ-022 The package SHALL be reused by the execute stage.
REQ-023 A combinational sub-module, decode_fields, SHALL map a 16-bit word to op, dst, src0, src1, imm, we, reads-src0, reads-src1 and illegal.
REQ-024 stage_decode SHALL own the decode register, hazard logic, halt latch and illegal pulse.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- 0x0B0A (ADD r3,r1,r2), pc_i=5 -> next cycle: op=1, dst=3, src0=1, src1=2, we=1, valid=1, dec_pc_o=5.
- 0x457F (LOADC r5,0x7F) -> imm=0x7F, dst=5, we=1; no stall.
- 0x3208 (LOAD r2,[r1]) then 0x0C10 (ADD r4,r2,r0) -> stall_o=1 for one cycle, one bubble, then ADD decoded. Repeat with 0x0C08 (no r2 use) -> no stall.
- 0x3208 then 0x0C10 with flush_i=1 in the stall cycle -> stall_o=0, bubble registered, no halt.
- 0xF800 (HALT) -> halt_o=1 and stays 1. Following 0x0B0A -> valid=0. rst_i pulse -> halt_o=0.
- 0x5800 (opcode 11) -> illegal_o=1 for exactly one cycle, valid=0. Back-to-back illegal words -> two consecutive pulses.
